// File: rtl/fifo_wr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and FIFO word-layout helpers for fifo_wr_arbiter and for the
// consumers that read its words back out of the FIFO.
// Word layout, MSB to LSB: {id[ID_W-1:0], last, payload[PAYLOAD_W-1:0]}.
// The helpers work on ARB_MAX_W-bit containers so one function serves any
// FIFO width up to ARB_MAX_W; callers slice the low FIFO_DWIDTH bits.
// ----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned ARB_MAX_W = 256;

    // Bit position of the last flag; also the payload width.
    function automatic int unsigned last_pos(input int unsigned dwidth,
                                             input int unsigned id_w);
        return dwidth - id_w - 1;
    endfunction

    // LSB position of the source id field.
    function automatic int unsigned id_lsb(input int unsigned dwidth,
                                           input int unsigned id_w);
        return dwidth - id_w;
    endfunction

    function automatic logic [ARB_MAX_W-1:0] pack_word(
        input logic [ARB_MAX_W-1:0] id,
        input logic                 last,
        input logic [ARB_MAX_W-1:0] payload,
        input int unsigned          dwidth,
        input int unsigned          id_w
    );
        logic [ARB_MAX_W-1:0] one;
        logic [ARB_MAX_W-1:0] pl_mask;
        logic [ARB_MAX_W-1:0] id_mask;
        one     = ARB_MAX_W'(1);
        pl_mask = (one << last_pos(dwidth, id_w)) - one;
        id_mask = (one << id_w) - one;
        return ((id & id_mask) << id_lsb(dwidth, id_w))
             | (ARB_MAX_W'(last) << last_pos(dwidth, id_w))
             | (payload & pl_mask);
    endfunction

    function automatic void unpack_word(
        input  logic [ARB_MAX_W-1:0] word,
        input  int unsigned          dwidth,
        input  int unsigned          id_w,
        output logic [ARB_MAX_W-1:0] id,
        output logic                 last,
        output logic [ARB_MAX_W-1:0] payload
    );
        logic [ARB_MAX_W-1:0] one;
        one     = ARB_MAX_W'(1);
        id      = (word >> id_lsb(dwidth, id_w)) & ((one << id_w) - one);
        last    = word[last_pos(dwidth, id_w)];
        payload = word & ((one << last_pos(dwidth, id_w)) - one);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: grants the first set bit of req found
// by searching cyclically from ptr+1. No request -> gnt = 0, idx = 0.
// Ports:
//   req  in  N     request vector
//   ptr  in  IW    index of the previous winner
//   gnt  out N     one-hot grant
//   idx  out IW    index of the granted bit
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]                       req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
    output logic [N-1:0]                       gnt,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic        found;
    int unsigned c;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        // k = N wraps back to ptr itself, so it has lowest priority.
        for (int unsigned k = 1; k <= N; k++) begin
            c = (32'(ptr) + k) % 32'(N);
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin, packet-aware arbiter sharing one sync_fifo write port among
// NUM_SRC producers. Each accepted beat is written one cycle later as
// {src_id, last, payload}; multi-beat packets are kept contiguous.
// Ports:
//   clk, rst    clock / async active-high reset
//   src_valid   per-source beat valid
//   src_last    per-source last-beat flag
//   src_data    packed per-source payloads (source i at [i*PAYLOAD_W +: ..])
//   src_ready   per-source accept (combinational)
//   fifo_wr_en  registered FIFO write strobe
//   fifo_wdata  registered FIFO write word
//   fifo_full   FIFO full flag
//   fifo_numel  FIFO occupancy
//   grant_id    most recently granted source
//   locked      mid-packet lock active
//   pkt_count   accepted last beats, wraps
// ----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int FIFO_DWIDTH = 64,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_SRC-1:0]                           src_valid,
    input  logic [NUM_SRC-1:0]                           src_last,
    input  logic [NUM_SRC*(FIFO_DWIDTH-$clog2(NUM_SRC)-1)-1:0] src_data,
    output logic [NUM_SRC-1:0]                           src_ready,
    output logic                                         fifo_wr_en,
    output logic [FIFO_DWIDTH-1:0]                       fifo_wdata,
    input  logic                                         fifo_full,
    input  logic [$clog2(FIFO_DEPTH):0]                  fifo_numel,
    output logic [$clog2(NUM_SRC)-1:0]                   grant_id,
    output logic                                         locked,
    output logic [15:0]                                  pkt_count
);
    localparam int ID_W      = $clog2(NUM_SRC);
    localparam int PAYLOAD_W = FIFO_DWIDTH - ID_W - 1;
    localparam int NUMEL_W   = $clog2(FIFO_DEPTH) + 1;

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        lock_id_q, lock_id_d;
    logic                   fifo_wr_en_q, fifo_wr_en_d;
    logic [FIFO_DWIDTH-1:0] fifo_wdata_q, fifo_wdata_d;
    logic [ID_W-1:0]        grant_id_q, grant_id_d;
    logic [15:0]            pkt_count_q, pkt_count_d;

    logic [NUM_SRC-1:0]     pick_gnt;
    logic [ID_W-1:0]        pick_idx;
    logic [ID_W-1:0]        sel_id;
    logic [PAYLOAD_W-1:0]   sel_payload;
    logic [ARB_MAX_W-1:0]   word_full;
    logic [NUMEL_W:0]       occ;
    logic                   can_write;
    logic                   accept;

    rr_pick #(.N(NUM_SRC)) u_pick (
        .req (src_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // The registered write still in flight counts as occupied space.
    always_comb begin
        occ       = {1'b0, fifo_numel} + {{NUMEL_W{1'b0}}, fifo_wr_en_q};
        can_write = !fifo_full && (occ < (NUMEL_W+1)'(FIFO_DEPTH));
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_id_d    = lock_id_q;
        fifo_wr_en_d = 1'b0;
        fifo_wdata_d = fifo_wdata_q;
        grant_id_d   = grant_id_q;
        pkt_count_d  = pkt_count_q;
        src_ready    = '0;

        sel_id      = (state_q == LOCKED) ? lock_id_q : pick_idx;
        sel_payload = src_data[32'(sel_id)*PAYLOAD_W +: PAYLOAD_W];
        word_full   = pack_word(ARB_MAX_W'(sel_id), src_last[sel_id],
                                ARB_MAX_W'(sel_payload), FIFO_DWIDTH, ID_W);

        if (!rst && can_write) begin
            if (state_q == LOCKED) src_ready[lock_id_q] = 1'b1;
            else                   src_ready            = pick_gnt;
        end
        accept = |(src_valid & src_ready);

        if (accept) begin
            fifo_wr_en_d = 1'b1;
            fifo_wdata_d = word_full[FIFO_DWIDTH-1:0];
            grant_id_d   = sel_id;
            if (src_last[sel_id]) begin
                state_d     = IDLE;
                rr_ptr_d    = sel_id;
                pkt_count_d = pkt_count_q + 16'd1;
            end else begin
                state_d   = LOCKED;
                lock_id_d = sel_id;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= ID_W'(NUM_SRC - 1);
            lock_id_q    <= '0;
            fifo_wr_en_q <= 1'b0;
            fifo_wdata_q <= '0;
            grant_id_q   <= '0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_id_q    <= lock_id_d;
            fifo_wr_en_q <= fifo_wr_en_d;
            fifo_wdata_q <= fifo_wdata_d;
            grant_id_q   <= grant_id_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign fifo_wr_en = fifo_wr_en_q;
    assign fifo_wdata = fifo_wdata_q;
    assign grant_id   = grant_id_q;
    assign locked     = (state_q == LOCKED);
    assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter (NUM_SRC=4, FIFO_DWIDTH=64, DEPTH=16)
// plus an exhaustive sweep of rr_pick. A small FIFO occupancy model drives
// fifo_full / fifo_numel from the DUT's own write strobe.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
    localparam int NS = 4;
    localparam int DW = 64;
    localparam int PW = 61;

    logic            clk;
    logic            rst;
    logic [NS-1:0]   src_valid;
    logic [NS-1:0]   src_last;
    logic [NS*PW-1:0] src_data;
    logic [NS-1:0]   src_ready;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wdata;
    logic            fifo_full;
    logic [4:0]      fifo_numel;
    logic [1:0]      grant_id;
    logic            locked;
    logic [15:0]     pkt_count;

    logic            rd;
    logic [4:0]      numel_m;
    int              wr_cnt;

    logic [3:0]      t_req;
    logic [1:0]      t_ptr;
    logic [3:0]      t_gnt;
    logic [1:0]      t_idx;

    int tests;
    int fails;

    fifo_wr_arbiter #(.NUM_SRC(NS), .FIFO_DWIDTH(DW), .FIFO_DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_last   (src_last),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .fifo_full  (fifo_full),
        .fifo_numel (fifo_numel),
        .grant_id   (grant_id),
        .locked     (locked),
        .pkt_count  (pkt_count)
    );

    rr_pick #(.N(4)) u_rr (
        .req (t_req),
        .ptr (t_ptr),
        .gnt (t_gnt),
        .idx (t_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO occupancy model: one write per wr_en, one pop per rd while non-empty.
    initial begin
        numel_m = '0;
        wr_cnt  = 0;
    end
    always @(posedge clk) begin
        if (fifo_wr_en) wr_cnt <= wr_cnt + 1;
        numel_m <= 5'(int'(numel_m) + (fifo_wr_en ? 1 : 0)
                                    - ((rd && numel_m != 5'd0) ? 1 : 0));
    end
    assign fifo_numel = numel_m;
    assign fifo_full  = (numel_m == 5'd16);

    function automatic logic [63:0] mk(input logic [1:0] id, input logic last,
                                       input logic [60:0] pl);
        return {id, last, pl};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        logic [7:0] dbl;
        logic [3:0] rot;
        logic [3:0] low;
        int j;
        int ei;

        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        rd        = 1'b1;
        src_valid = 4'hF;
        src_last  = '0;
        src_data  = '0;
        t_req     = '0;
        t_ptr     = '0;

        // Reset state
        repeat (2) step();
        check("rst_wr_en",   64'(fifo_wr_en), 64'd0);
        check("rst_wdata",   fifo_wdata,      64'd0);
        check("rst_grant",   64'(grant_id),   64'd0);
        check("rst_locked",  64'(locked),     64'd0);
        check("rst_pkt",     64'(pkt_count),  64'd0);
        check("rst_ready",   64'(src_ready),  64'd0);
        src_valid = '0;
        rst = 1'b0;

        // Single beat from source 0
        step();
        src_valid = 4'b0001;
        src_last  = 4'b0001;
        src_data[0*PW +: PW] = 61'h1234;
        #1;
        check("t1_ready", 64'(src_ready), 64'h1);
        step();
        src_valid = '0;
        check("t1_wr_en", 64'(fifo_wr_en), 64'd1);
        check("t1_wdata", fifo_wdata, 64'h2000_0000_0000_1234);
        check("t1_pkt",   64'(pkt_count), 64'd1);
        step();
        check("t1_wr_drop", 64'(fifo_wr_en), 64'd0);
        check("t1_hold",    fifo_wdata, 64'h2000_0000_0000_1234);

        // Round robin over four always-valid single-beat sources
        do_reset();
        for (int i = 0; i < NS; i++) src_data[i*PW +: PW] = 61'(8'hA0 + i);
        src_valid = 4'hF;
        src_last  = 4'hF;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("rr_wr%0d", k), 64'(fifo_wr_en), 64'd1);
            check($sformatf("rr_word%0d", k), fifo_wdata,
                  mk(2'(k % 4), 1'b1, 61'(8'hA0 + (k % 4))));
        end
        src_valid = '0;
        check("rr_pkt", 64'(pkt_count), 64'd8);

        // Source 1 three-beat packet, source 2 waiting
        src_data[1*PW +: PW] = 61'h111;
        src_data[2*PW +: PW] = 61'h222;
        src_valid = 4'b0110;
        src_last  = 4'b0100;
        step();
        check("pk_b1",     fifo_wdata, mk(2'd1, 1'b0, 61'h111));
        check("pk_lock1",  64'(locked), 64'd1);
        check("pk_ready",  64'(src_ready), 64'b0010);
        step();
        check("pk_b2",     fifo_wdata, mk(2'd1, 1'b0, 61'h111));
        check("pk_lock2",  64'(locked), 64'd1);
        src_last = 4'b0110;
        step();
        check("pk_b3",     fifo_wdata, mk(2'd1, 1'b1, 61'h111));
        check("pk_lock3",  64'(locked), 64'd0);
        src_valid = 4'b0100;
        step();
        check("pk_s2",     fifo_wdata, mk(2'd2, 1'b1, 61'h222));
        check("pk_s2_wr",  64'(fifo_wr_en), 64'd1);
        src_valid = '0;

        // Fill the FIFO with no reads
        repeat (3) step();
        do_reset();
        rd = 1'b0;
        check("full_start", 64'(numel_m), 64'd0);
        w0 = wr_cnt;
        src_valid = 4'hF;
        src_last  = 4'hF;
        repeat (20) step();
        check("full_writes", 64'(wr_cnt - w0), 64'd16);
        check("full_numel",  64'(fifo_numel),  64'd16);
        check("full_ready",  64'(src_ready),   64'd0);
        check("full_wr_en",  64'(fifo_wr_en),  64'd0);
        w0 = wr_cnt;
        rd = 1'b1;
        step();
        rd = 1'b0;
        repeat (6) step();
        check("full_one_more", 64'(wr_cnt - w0), 64'd1);
        check("full_numel2",   64'(fifo_numel),   64'd16);
        src_valid = '0;

        // Reset while source 3 holds the lock
        rd = 1'b1;
        repeat (20) step();
        do_reset();
        src_valid = 4'b1000;
        src_last  = 4'b0000;
        #1;
        check("mr_ready", 64'(src_ready), 64'b1000);
        step();
        check("mr_locked", 64'(locked), 64'd1);
        check("mr_grant",  64'(grant_id), 64'd3);
        rst = 1'b1;
        #1;
        check("mr_wr_drop",   64'(fifo_wr_en), 64'd0);
        check("mr_lock_drop", 64'(locked),     64'd0);
        check("mr_ready_rst", 64'(src_ready),  64'd0);
        step();
        rst = 1'b0;
        src_valid = 4'hF;
        src_last  = 4'hF;
        step();
        check("mr_first_grant", 64'(grant_id), 64'd0);
        check("mr_first_word",  fifo_wdata, mk(2'd0, 1'b1, 61'hA0));
        check("mr_pkt",         64'(pkt_count), 64'd1);
        src_valid = '0;

        // rr_pick exhaustive sweep, reference uses rotate + lowest-set-bit
        for (int r = 0; r < 16; r++) begin
            for (int p = 0; p < 4; p++) begin
                t_req = 4'(r);
                t_ptr = 2'(p);
                #1;
                dbl = {t_req, t_req};
                rot = 4'(dbl >> (p + 1));
                if (rot == 4'd0) begin
                    check($sformatf("pick_none_r%0d_p%0d", r, p), 64'(t_gnt), 64'd0);
                end else begin
                    low = rot & (~rot + 4'd1);
                    j   = $clog2(low);
                    ei  = (p + 1 + j) % 4;
                    check($sformatf("pick_gnt_r%0d_p%0d", r, p), 64'(t_gnt), 64'(1 << ei));
                    check($sformatf("pick_idx_r%0d_p%0d", r, p), 64'(t_idx), 64'(ei));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
